// File: rtl/control_unit.sv
// Multi-cycle sequencer and decoder for a 64-bit LEGv8 subset, together with the
// datapath it drives (PC, register file, ALU, status, IR, AR and word memory).

module ram (
  input  logic        clock,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [63:0] din,
  output logic [63:0] dout
);
  logic [63:0] mem [0:4095];

  // Word write port; memory contents survive reset on purpose.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];
endmodule

module datapath (
  input  logic              clock,
  input  logic              reset,
  input  logic [29:0]       ctl,
  input  logic [63:0]       k,
  output logic [31:0]       ir_out,
  output logic [3:0]        status,
  output logic [31:0][63:0] regs
);
  logic [63:0] rf_r [0:31];
  logic [63:0] pc_r, ar_r, a_s, breg_s, b_s, alu_s, bus_s, dout_s;
  logic [64:0] sum_s;
  logic [31:0] ir_r;
  logic [3:0]  status_r, flags_s;
  logic [11:0] idx_s;
  logic        c_s, v_s, unused_ok_s;

  assign a_s    = (ctl[9:5] == 5'd31) ? 64'd0 : rf_r[ctl[9:5]];
  assign breg_s = (ctl[14:10] == 5'd31) ? 64'd0 : rf_r[ctl[14:10]];
  assign b_s    = ctl[23] ? k : breg_s;
  assign idx_s  = ctl[29] ? ar_r[13:2] : pc_r[13:2];
  assign unused_ok_s = ^{ar_r[63:14], ar_r[1:0], pc_r[63:14], pc_r[1:0]};

  ram randomAccess (.clock(clock), .we(ctl[20] & reset), .addr(idx_s), .din(breg_s), .dout(dout_s));

  // ALU; carry is "no borrow" for subtraction.
  always_comb begin
    sum_s = 65'd0;
    alu_s = 64'd0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (ctl[18:15])
      4'd0: alu_s = a_s & b_s;
      4'd1: alu_s = a_s | b_s;
      4'd2: begin
        sum_s = {1'b0, a_s} + {1'b0, b_s};
        alu_s = sum_s[63:0];
        c_s   = sum_s[64];
        v_s   = (a_s[63] == b_s[63]) && (alu_s[63] != a_s[63]);
      end
      4'd3: begin
        sum_s = {1'b0, a_s} + {1'b0, ~b_s} + 65'd1;
        alu_s = sum_s[63:0];
        c_s   = sum_s[64];
        v_s   = (a_s[63] != b_s[63]) && (alu_s[63] != a_s[63]);
      end
      4'd4: alu_s = a_s ^ b_s;
      4'd5: alu_s = a_s << b_s[5:0];
      4'd6: alu_s = a_s >> b_s[5:0];
      4'd7: alu_s = b_s;
      default: alu_s = 64'd0;
    endcase
  end

  assign flags_s = {alu_s[63], (alu_s == 64'd0), c_s, v_s};

  // Bus source select.
  always_comb begin
    if (ctl[22]) begin
      bus_s = alu_s;
    end else if (ctl[21]) begin
      bus_s = dout_s;
    end else begin
      bus_s = 64'd0;
    end
  end

  // PC, IR, AR and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r     <= 64'd0;
      ir_r     <= 32'd0;
      ar_r     <= 64'd0;
      status_r <= 4'd0;
    end else begin
      case (ctl[25:24])
        2'b01:   pc_r <= pc_r + 64'd4;
        2'b10:   pc_r <= pc_r + {k[61:0], 2'b00};
        2'b11:   pc_r <= a_s;
        default: pc_r <= pc_r;
      endcase
      if (ctl[26]) ir_r <= bus_s[31:0];
      if (ctl[28]) ar_r <= alu_s;
      if (ctl[27]) status_r <= flags_s;
    end
  end

  // Register file; index 31 is never written so it stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 64'd0;
    end else if (ctl[19] && (ctl[4:0] != 5'd31)) begin
      rf_r[ctl[4:0]] <= bus_s;
    end
  end

  // Register export with XZR forced to zero.
  always_comb begin
    for (int i = 0; i < 31; i++) regs[i] = rf_r[i];
    regs[31] = 64'd0;
  end

  assign ir_out = ir_r;
  assign status = status_r;
endmodule

module control_unit (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  output logic [63:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
  output logic [63:0] r16, r17, r18, r19, r20, r21, r22, r23,
  output logic [63:0] r24, r25, r26, r27, r28, r29, r30, r31,
  output logic [95:0] controlWord
);
  typedef enum logic [1:0] {ST_IF = 2'd0, ST_EX0 = 2'd1, ST_EX1 = 2'd2, ST_EX2 = 2'd3} state_t;
  localparam logic [95:0] IF_WORD = 96'h0000_0000_0000_0000_4520_0000;
  localparam logic [3:0]  FS_AND = 4'd0, FS_ORR = 4'd1, FS_ADD = 4'd2, FS_SUB = 4'd3;
  localparam logic [3:0]  FS_EOR = 4'd4, FS_LSL = 4'd5, FS_LSR = 4'd6, FS_PASS = 4'd7;

  state_t            state_r, state_nxt_s;
  logic [31:0]       ir_s;
  logic [3:0]        status_s, fs_s;
  logic [31:0][63:0] regs_s;
  logic [95:0]       ex0_s, ex1_s;
  logic [63:0]       k_s;
  logic              alu_ok_s, use_k_s, sl_s;

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0:    r = z;
      3'd1:    r = c;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = c & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return (cond[3:1] == 3'd7) ? 1'b1 : (r ^ cond[0]);
  endfunction

  datapath path (.clock(clock), .reset(reset), .ctl(controlWord[29:0]), .k(controlWord[95:32]),
                 .ir_out(ir_s), .status(status_s), .regs(regs_s));

  // EX0/EX1 words decoded from the latched instruction and current flags.
  always_comb begin
    ex0_s = 96'd0;
    ex1_s = 96'd0;
    alu_ok_s = 1'b1;
    use_k_s = 1'b0;
    sl_s = 1'b0;
    fs_s = FS_ADD;
    k_s = 64'd0;
    casez (ir_s[31:21])
      11'b10001011000: fs_s = FS_ADD;
      11'b11001011000: fs_s = FS_SUB;
      11'b10001010000: fs_s = FS_AND;
      11'b10101010000: fs_s = FS_ORR;
      11'b11001010000: fs_s = FS_EOR;
      11'b10101011000: begin fs_s = FS_ADD; sl_s = 1'b1; end
      11'b11101011000: begin fs_s = FS_SUB; sl_s = 1'b1; end
      11'b1001000100?: begin fs_s = FS_ADD; use_k_s = 1'b1; k_s = {52'd0, ir_s[21:10]}; end
      11'b1101000100?: begin fs_s = FS_SUB; use_k_s = 1'b1; k_s = {52'd0, ir_s[21:10]}; end
      11'b1001001000?: begin fs_s = FS_AND; use_k_s = 1'b1; k_s = {52'd0, ir_s[21:10]}; end
      11'b1011001000?: begin fs_s = FS_ORR; use_k_s = 1'b1; k_s = {52'd0, ir_s[21:10]}; end
      11'b1101001000?: begin fs_s = FS_EOR; use_k_s = 1'b1; k_s = {52'd0, ir_s[21:10]}; end
      11'b11010011011: begin fs_s = FS_LSL; use_k_s = 1'b1; k_s = {58'd0, ir_s[15:10]}; end
      11'b11010011010: begin fs_s = FS_LSR; use_k_s = 1'b1; k_s = {58'd0, ir_s[15:10]}; end
      11'b110100101??: begin
        fs_s = FS_PASS;
        use_k_s = 1'b1;
        k_s = {48'd0, ir_s[20:5]} << {ir_s[22:21], 4'b0000};
      end
      default: alu_ok_s = 1'b0;
    endcase
    if (alu_ok_s) begin
      ex0_s[4:0]   = ir_s[4:0];
      ex0_s[9:5]   = ir_s[9:5];
      ex0_s[14:10] = use_k_s ? 5'd0 : ir_s[20:16];
      ex0_s[18:15] = fs_s;
      ex0_s[19]    = 1'b1;
      ex0_s[22]    = 1'b1;
      ex0_s[23]    = use_k_s;
      ex0_s[27]    = sl_s;
      ex0_s[95:32] = k_s;
    end else if ((ir_s[31:21] == 11'b11111000010) || (ir_s[31:21] == 11'b11111000000)) begin
      ex0_s[9:5]   = ir_s[9:5];
      ex0_s[18:15] = FS_ADD;
      ex0_s[23]    = 1'b1;
      ex0_s[28]    = 1'b1;
      ex0_s[31:30] = 2'd2;
      ex0_s[95:32] = {{55{ir_s[20]}}, ir_s[20:12]};
      ex1_s[29]    = 1'b1;
      if (ir_s[22]) begin
        ex1_s[4:0] = ir_s[4:0];
        ex1_s[19]  = 1'b1;
        ex1_s[21]  = 1'b1;
      end else begin
        ex1_s[14:10] = ir_s[4:0];
        ex1_s[20]    = 1'b1;
      end
    end else if (ir_s[31:26] == 6'b000101) begin
      ex0_s[25:24] = 2'b10;
      ex0_s[95:32] = {{38{ir_s[25]}}, ir_s[25:0]} - 64'd1;
    end else if (ir_s[31:24] == 8'b01010100) begin
      if (cond_true(ir_s[3:0], status_s)) begin
        ex0_s[25:24] = 2'b10;
        ex0_s[95:32] = {{45{ir_s[23]}}, ir_s[23:5]} - 64'd1;
      end else begin
        ex0_s[25:24] = 2'b00;
      end
    end else if (ir_s[31:21] == 11'b11010110000) begin
      ex0_s[9:5]   = ir_s[9:5];
      ex0_s[25:24] = 2'b11;
    end else begin
      ex0_s = 96'd0;
    end
  end

  // Control word select; its NS field is the next state.
  always_comb begin
    case (state_r)
      ST_IF:   controlWord = IF_WORD;
      ST_EX0:  controlWord = ex0_s;
      ST_EX1:  controlWord = ex1_s;
      default: controlWord = 96'd0;
    endcase
    state_nxt_s = state_t'(controlWord[31:30]);
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign {r31, r30, r29, r28, r27, r26, r25, r24} = regs_s[31:24];
  assign {r23, r22, r21, r20, r19, r18, r17, r16} = regs_s[23:16];
  assign {r15, r14, r13, r12, r11, r10, r9,  r8}  = regs_s[15:8];
  assign {r7,  r6,  r5,  r4,  r3,  r2,  r1,  r0}  = regs_s[7:0];
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of two-instruction programs plus
// hand-written sequences for memory ops, branches and mid-instruction reset.

module tb_control_unit;
  logic        clock, reset;
  logic [63:0] rv [0:31];
  logic [95:0] controlWord;
  int          checks, failures;

  typedef struct {
    string       name;
    logic [31:0] i0;
    logic [31:0] i1;
    int          rd;
    logic [63:0] val;
    logic [3:0]  nzcv;
  } vec_t;
  vec_t vecs [16];

  control_unit dut (
    .clock(clock), .reset(reset),
    .r0(rv[0]),   .r1(rv[1]),   .r2(rv[2]),   .r3(rv[3]),   .r4(rv[4]),   .r5(rv[5]),
    .r6(rv[6]),   .r7(rv[7]),   .r8(rv[8]),   .r9(rv[9]),   .r10(rv[10]), .r11(rv[11]),
    .r12(rv[12]), .r13(rv[13]), .r14(rv[14]), .r15(rv[15]), .r16(rv[16]), .r17(rv[17]),
    .r18(rv[18]), .r19(rv[19]), .r20(rv[20]), .r21(rv[21]), .r22(rv[22]), .r23(rv[23]),
    .r24(rv[24]), .r25(rv[25]), .r26(rv[26]), .r27(rv[27]), .r28(rv[28]), .r29(rv[29]),
    .r30(rv[30]), .r31(rv[31]), .controlWord(controlWord)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] itype(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
    return {op, imm, rn, rd};
  endfunction

  function automatic logic [31:0] shtype(input logic [10:0] op, input logic [5:0] sh, input logic [4:0] rn, rd);
    return {op, 5'd0, sh, rn, rd};
  endfunction

  task automatic load(input int idx, input logic [31:0] w);
    dut.path.randomAccess.mem[idx] = {32'd0, w};
  endtask

  localparam logic [31:0] ADDI5 = 32'h910017E1;

  initial begin
    logic [31:0] subi_m1, movz_min;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    subi_m1  = itype(10'b1101000100, 12'd1, 5'd31, 5'd1);
    movz_min = {9'b110100101, 2'b11, 16'h8000, 5'd1};

    vecs[0]  = '{"add",   ADDI5, rtype(11'b10001011000, 5'd1, 5'd1, 5'd2), 2, 64'd10, 4'b0000};
    vecs[1]  = '{"sub",   ADDI5, rtype(11'b11001011000, 5'd1, 5'd1, 5'd2), 2, 64'd0, 4'b0000};
    vecs[2]  = '{"andi",  ADDI5, itype(10'b1001001000, 12'd6, 5'd1, 5'd2), 2, 64'd4, 4'b0000};
    vecs[3]  = '{"orri",  ADDI5, itype(10'b1011001000, 12'd10, 5'd1, 5'd2), 2, 64'd15, 4'b0000};
    vecs[4]  = '{"eori",  ADDI5, itype(10'b1101001000, 12'd6, 5'd1, 5'd2), 2, 64'd3, 4'b0000};
    vecs[5]  = '{"orr",   ADDI5, rtype(11'b10101010000, 5'd31, 5'd1, 5'd2), 2, 64'd5, 4'b0000};
    vecs[6]  = '{"eor",   ADDI5, rtype(11'b11001010000, 5'd1, 5'd1, 5'd2), 2, 64'd0, 4'b0000};
    vecs[7]  = '{"lsl",   ADDI5, shtype(11'b11010011011, 6'd4, 5'd1, 5'd2), 2, 64'd80, 4'b0000};
    vecs[8]  = '{"lsr",   ADDI5, shtype(11'b11010011010, 6'd1, 5'd1, 5'd2), 2, 64'd2, 4'b0000};
    vecs[9]  = '{"subi",  ADDI5, itype(10'b1101000100, 12'd7, 5'd1, 5'd2), 2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000};
    vecs[10] = '{"subs",  ADDI5, rtype(11'b11101011000, 5'd1, 5'd1, 5'd2), 2, 64'd0, 4'b0110};
    vecs[11] = '{"adds",  subi_m1, rtype(11'b10101011000, 5'd1, 5'd1, 5'd2), 2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
    vecs[12] = '{"movz",  ADDI5, {9'b110100101, 2'b01, 16'h1234, 5'd2}, 2, 64'h1234_0000, 4'b0000};
    vecs[13] = '{"xzr",   ADDI5, itype(10'b1001000100, 12'd3, 5'd1, 5'd31), 31, 64'd0, 4'b0000};
    vecs[14] = '{"addsv", movz_min, rtype(11'b10101011000, 5'd1, 5'd1, 5'd2), 2, 64'd0, 4'b0111};
    vecs[15] = '{"subsn", ADDI5, rtype(11'b11101011000, 5'd1, 5'd31, 5'd2), 2, 64'hFFFF_FFFF_FFFF_FFFB, 4'b1000};

    // Reset state and first transition.
    @(negedge clock);
    load(0, ADDI5);
    load(1, 32'hEB010022);
    load(2, 32'h54000040);
    load(3, 32'h00000000);
    load(4, 32'hF80083E1);
    load(5, 32'hF84083E3);
    load(6, 32'h00000000);
    load(7, 32'h54000041);
    load(8, 32'h17FFFFF8);
    #1;
    chk("rst_state", {62'd0, dut.state_r}, 64'd0);
    chk("rst_pc", dut.path.pc_r, 64'd0);
    chk("rst_cw_lo", controlWord[63:0], 64'h0000_0000_4520_0000);
    chk("rst_cw_hi", {32'd0, controlWord[95:64]}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step(1);
    chk("rel_state", {62'd0, dut.state_r}, 64'd1);
    step(1);
    chk("addi_r1", rv[1], 64'd5);
    chk("addi_pc", dut.path.pc_r, 64'd4);
    chk("addi_state", {62'd0, dut.state_r}, 64'd0);
    step(4);
    chk("subs_r2", rv[2], 64'd0);
    chk("subs_flags", {60'd0, dut.path.status_r}, 64'd6);
    chk("beq_pc", dut.path.pc_r, 64'h10);
    for (int s = 1; s <= 3; s++) begin
      step(1);
      chk($sformatf("stur_state%0d", s), {62'd0, dut.state_r}, 64'(s % 3));
    end
    chk("stur_mem", dut.path.randomAccess.mem[2], 64'd5);
    chk("stur_pc", dut.path.pc_r, 64'h14);
    step(3);
    chk("ldur_r3", rv[3], 64'd5);
    chk("ldur_pc", dut.path.pc_r, 64'h18);
    step(2);
    chk("nop_pc", dut.path.pc_r, 64'h1C);
    chk("nop_r1", rv[1], 64'd5);
    chk("nop_r3", rv[3], 64'd5);
    chk("nop_mem", dut.path.randomAccess.mem[2], 64'd5);
    chk("nop_flags", {60'd0, dut.path.status_r}, 64'd6);
    step(2);
    chk("bne_pc", dut.path.pc_r, 64'h20);
    step(2);
    chk("b_back_pc", dut.path.pc_r, 64'd0);

    // Table of two-instruction programs, each from a fresh reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      reset = 1'b0;
      load(0, vecs[i].i0);
      load(1, vecs[i].i1);
      @(negedge clock);
      reset = 1'b1;
      step(4);
      chk({vecs[i].name, "_rd"}, rv[vecs[i].rd], vecs[i].val);
      chk({vecs[i].name, "_flags"}, {60'd0, dut.path.status_r}, {60'd0, vecs[i].nzcv});
      chk({vecs[i].name, "_pc"}, dut.path.pc_r, 64'd8);
      chk({vecs[i].name, "_state"}, {62'd0, dut.state_r}, 64'd0);
    end

    // Reset asserted in the middle of a STUR.
    @(negedge clock);
    reset = 1'b0;
    load(0, itype(10'b1001000100, 12'd7, 5'd31, 5'd1));
    load(1, 32'hF80083E1);
    dut.path.randomAccess.mem[2] = 64'hAA;
    @(negedge clock);
    reset = 1'b1;
    step(2);
    chk("mid_r1", rv[1], 64'd7);
    step(2);
    chk("mid_state2", {62'd0, dut.state_r}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_state", {62'd0, dut.state_r}, 64'd0);
    chk("mid_rst_pc", dut.path.pc_r, 64'd0);
    chk("mid_rst_r1", rv[1], 64'd0);
    chk("mid_rst_cw", controlWord[63:0], 64'h0000_0000_4520_0000);
    step(1);
    chk("mid_rst_mem", dut.path.randomAccess.mem[2], 64'hAA);
    @(negedge clock);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
